// File: rtl/xor_bist_pkg.sv
// xor_bist_pkg: shared FSM type and sizing constants for the XOR self-test engine
package xor_bist_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} xor_bist_state_t;
   localparam int XB_WIDTH    = 4;
   localparam int NUM_VECTORS = 1 << (2 * XB_WIDTH);
   localparam int SETTLE_W    = 4;
endpackage

// File: rtl/xor_bist_vecgen.sv
// xor_bist_vecgen: vector index, settle timer and registered operand outputs
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : restart at vector 0 and reset the settle timer
//   advance_i    : step to the next vector
//   drive_i      : current vector is settling; timer runs only while high
//   a_o, b_o     : operands, upper and lower halves of the index
//   last_o       : index is all-ones
//   settled_o    : final settle cycle of the current vector
module xor_bist_vecgen
   import xor_bist_pkg::*;
#(
   parameter int WIDTH  = XB_WIDTH,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic             drive_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             last_o,
   output logic             settled_o
);
   logic [2*WIDTH-1:0]  idx_q, idx_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   assign {a_o, b_o} = idx_q;
   assign last_o     = &idx_q;
   assign settled_o  = drive_i && cnt_q == SETTLE_W'(SETTLE - 1);
   always_comb begin
      idx_d = clear_i ? '0 : advance_i ? idx_q + (2*WIDTH)'(1) : idx_q;
      cnt_d = (clear_i || !drive_i || settled_o) ? '0 : cnt_q + SETTLE_W'(1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/xor_bist.sv
// xor_bist: exhaustive self-test of a WIDTH-bit XOR gate with first-fail capture
//   clk, rst_n              : clock, async active-low reset
//   start_i                 : begin a run (accepted only in IDLE or DONE)
//   a_o, b_o                : operands driven to the gate under test
//   x_i                     : gate result
//   busy_o, done_o, pass_o  : run status; pass is done with zero mismatches
//   err_cnt_o               : saturating mismatch count
//   fail_valid_o, fail_a_o, fail_b_o, fail_x_o : first mismatch record
module xor_bist
   import xor_bist_pkg::*;
#(
   parameter int WIDTH  = XB_WIDTH,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   input  logic [WIDTH-1:0] x_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [2*WIDTH:0] err_cnt_o,
   output logic             fail_valid_o,
   output logic [WIDTH-1:0] fail_a_o,
   output logic [WIDTH-1:0] fail_b_o,
   output logic [WIDTH-1:0] fail_x_o
);
   // saturation point equals the vector count, so every vector can fail once
   localparam logic [2*WIDTH:0] ERR_MAX = {1'b1, {(2*WIDTH){1'b0}}};
   xor_bist_state_t  state_q, state_d;
   logic             accept, sample, mismatch, capture, last, settled;
   logic [2*WIDTH:0] err_q, err_d;
   logic             fv_q, fv_d;
   logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fx_q, fx_d;
   assign accept   = start_i && (state_q == IDLE || state_q == DONE);
   assign sample   = state_q == SAMPLE;
   assign mismatch = sample && x_i != (a_o ^ b_o);
   assign capture  = mismatch && !fv_q;
   xor_bist_vecgen #(.WIDTH(WIDTH), .SETTLE(SETTLE)) u_vecgen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (accept),
      .advance_i (sample && !last),
      .drive_i   (state_q == DRIVE),
      .a_o       (a_o),
      .b_o       (b_o),
      .last_o    (last),
      .settled_o (settled)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = start_i ? DRIVE : state_q;
         DRIVE:      state_d = settled ? SAMPLE : DRIVE;
         SAMPLE:     state_d = last ? DONE : DRIVE;
         default:    state_d = IDLE;
      endcase
      err_d = accept ? '0 : (mismatch && err_q != ERR_MAX) ? err_q + (2*WIDTH+1)'(1) : err_q;
      fv_d  = accept ? 1'b0 : fv_q | capture;
      fa_d  = accept ? '0 : capture ? a_o : fa_q;
      fb_d  = accept ? '0 : capture ? b_o : fb_q;
      fx_d  = accept ? '0 : capture ? x_i : fx_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         fx_q    <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         fx_q    <= fx_d;
      end
   end
   assign busy_o       = state_q == DRIVE || state_q == SAMPLE;
   assign done_o       = state_q == DONE;
   assign pass_o       = done_o && err_q == '0;
   assign err_cnt_o    = err_q;
   assign fail_valid_o = fv_q;
   assign fail_a_o     = fa_q;
   assign fail_b_o     = fb_q;
   assign fail_x_o     = fx_q;
endmodule

// File: doc/xor_bist.md
# xor_bist

Synthesizable built-in self-test engine for the 4-bit XOR block (inputs `a`, `b`; output `x`). It drives all 256 `{a,b}` operand pairs into the gate under test, samples `x` after a programmable settle time, and compares it against `a ^ b`. It reports pass/fail, a mismatch count and the first failing vector. It sits beside the gate on the board and replaces the simulation-only stimulus bench.

## Interface
- `WIDTH`, 4: operand width. The vector space is 2^(2·WIDTH).
- `SETTLE`, 1: cycles to wait after driving a vector before sampling `x`. Legal range is 1..15.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: begins a run. Sampled only in IDLE or DONE.
- `a`  out  WIDTH: operand A to the gate under test.
- `b`  out  WIDTH: operand B to the gate under test.
- `x`  in  WIDTH: result from the gate under test.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: high from run completion until the next accepted `start`.
- `pass`  out  1: `done && err_cnt == 0`.
- `err_cnt`  out  2·WIDTH+1: mismatch count. Saturates at 2^(2·WIDTH).
- `fail_valid`  out  1: a first failure has been captured.
- `fail_a`, `fail_b`, `fail_x`  out  WIDTH each: operands and observed result of the first mismatch.

## Operation
- Reset sets every output to 0 and the FSM to IDLE.
- States and transitions:
  - IDLE: waits for `start`, then goes to DRIVE.
  - DRIVE: holds the vector for `SETTLE` cycles, then goes to SAMPLE.
  - SAMPLE: compares for one cycle. Goes to DRIVE if the index is below its maximum; otherwise goes to DONE.
  - DONE: goes to DRIVE on `start`.
- On `start` accepted in IDLE or DONE:
  - Clear the index, `err_cnt`, `fail_*` and `done`.
  - Set `busy`.
  - Drive vector 0.
- Vector index `idx` is 2·WIDTH bits. `a = idx[2W-1:W]` and `b = idx[W-1:0]`. `a` and `b` are registered outputs and stay stable through DRIVE and SAMPLE.
- In SAMPLE, compare `x` with `a ^ b`. On mismatch:
  - Increment `err_cnt` (saturating).
  - If `fail_valid == 0`, capture `a`, `b`, `x` and set `fail_valid`.
- After sampling, `idx` increments. After sampling `idx` = all-ones, go to DONE:
  - `busy` = 0, `done` = 1.
  - `a` and `b` hold the last vector.
  - Results hold until the next accepted `start`.
- `start` while `busy` is ignored, whether a new pulse or held high. `start` held high through DONE restarts immediately.
- Reset asserted mid-run aborts the run. All outputs return to 0 asynchronously, and no partial result is retained.

## Timing
- `start` sampled high at edge N gives `busy` = 1 and vector 0 on `a`/`b` after edge N.
- Each vector occupies SETTLE+1 cycles. The first `x` sample of each vector occurs at the SETTLE+1th edge after it is driven.
- `done` rises 256·(SETTLE+1) cycles after the accepting edge (512 cycles for SETTLE=1). `busy` falls on the same edge.
- `err_cnt` and `fail_*` update on the SAMPLE edge and are visible the following cycle.
- `pass` is combinational from registered `done` and `err_cnt`, so it has no extra latency.
- The gate under test must settle within SETTLE clock periods.

## Structure
- Package `xor_bist_pkg` contains:
  - The FSM state enum `xor_bist_state_t` (IDLE, DRIVE, SAMPLE, DONE).
  - The constant `NUM_VECTORS = 1 << (2*WIDTH)`.
  - The settle-counter width constant.
- Sub-module `xor_bist_vecgen` contains the index counter, settle counter and `a`/`b` output registers. It takes `clear` and `advance` and produces `last` and `settled`.
- The top level holds the FSM, the comparator, the error counter and the first-fail capture registers.

## Test plan
- Golden XOR on `x`, pulse `start` -> `done` = 1 after 512 cycles, `pass` = 1, `err_cnt` = 0, `fail_valid` = 0.
- `x[0]` stuck-at-0 -> `err_cnt` = 128, first fail captured as `fail_a` = 0, `fail_b` = 1, `fail_x` = 0, `pass` = 0.
- `x` = ~(a^b) -> `err_cnt` = 256 (saturation value reached), first fail `a` = 0, `b` = 0, `x` = 4'hF.
- Deassert `rst_n` at cycle 100 of a run -> all outputs 0 immediately, FSM in IDLE. A following `start` gives a clean 512-cycle pass.
- `start` held high for 600 cycles -> exactly one run while `busy`. A second run begins on the edge after `done`, and `done` clears when that `start` is accepted.
- `SETTLE` = 3 with the golden gate -> `done` after 1024 cycles. `a`/`b` stay stable 4 cycles per vector.
